// File: rtl/aes_subbytes_seq.sv
// Forward AES SubBytes, LANES bytes per cycle through shared S-box read ports.
// Define SUBBYTES_SHIFTROWS_EN to fuse ShiftRows into the final copy to out_data.
module aes_subbytes_seq #(
    parameter int LANES     = 4,
    parameter     SBOX_FILE = "sbox.txt"
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int NCHUNK = 16 / LANES;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (LANES != 1 && LANES != 2 && LANES != 4 &&
        LANES != 8 && LANES != 16) begin : g_bad_lanes
        $error("aes_subbytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end

    // Forward S-box contents are built in, so the ROM needs no load step.
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        DONE
    } state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [127:0]  work_q;
    logic [127:0]  work_d;
    logic [127:0]  out_data_q;
    logic [127:0]  out_data_d;
    logic          out_valid_q;
    logic          last_chunk;

    logic [3:0]    lane_idx [LANES];
    logic [7:0]    lane_in  [LANES];
    logic [7:0]    lane_out [LANES];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_idx[l] = 4'(int'(cnt_q) * LANES + l);
        assign lane_in[l]  = work_q[8*lane_idx[l] +: 8];
        assign lane_out[l] = SBOX[lane_in[l]];
    end

    always_comb begin
        work_d = work_q;
        for (int l = 0; l < LANES; l++) begin
            work_d[8*lane_idx[l] +: 8] = lane_out[l];
        end
    end

    // Column-major state: byte r+4c is row r, column c.
    function automatic logic [127:0] final_perm(input logic [127:0] s);
        logic [127:0] p;
        p = s;
`ifdef SUBBYTES_SHIFTROWS_EN
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                p[8*(r+4*c) +: 8] = s[8*(r+4*((c+r)%4)) +: 8];
            end
        end
`endif
        return p;
    endfunction

    assign out_data_d = final_perm(work_d);
    assign last_chunk = (cnt_q == CW'(NCHUNK-1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        work_q  <= in_data;
                        cnt_q   <= '0;
                        state_q <= SUB;
                    end
                end
                SUB: begin
                    work_q <= work_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (last_chunk) begin
                        out_data_q  <= out_data_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_aes_subbytes_seq.sv
// Bench for aes_subbytes_seq: GF(2^8)-derived S-box model, per-cycle
// output comparison, directed cases and a randomized handshake stream.
module tb_aes_subbytes_seq;

    localparam int LANES  = 4;
    localparam int NCHUNK = 16 / LANES;

    logic         clk       = 1'b0;
    logic         rst       = 1'b1;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] in_data   = '0;
    logic         in_ready;
    logic         out_valid;
    logic         busy;
    logic [127:0] out_data;

    int checks   = 0;
    int failures = 0;

    logic [7:0] sbox_m [256];

    aes_subbytes_seq #(.LANES(LANES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] p;
        logic       hi;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = a << 1;
            if (hi) a = a ^ 8'h1b;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    function automatic logic [127:0] expect_fn(input logic [127:0] d);
        logic [7:0]   s [16];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) s[i] = sbox_m[d[8*i +: 8]];
        o = '0;
`ifdef SUBBYTES_SHIFTROWS_EN
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[8*(r+4*c) +: 8] = s[r + 4*((c + r) % 4)];
`else
        for (int i = 0; i < 16; i++) o[8*i +: 8] = s[i];
`endif
        return o;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: accept, NCHUNK cycles of work, then hold until drained.
    int           m_phase = 0;
    int           m_left  = 0;
    logic [127:0] m_pend  = '0;
    logic [127:0] m_od    = '0;
    logic         m_ov    = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0;
            m_ov    = 1'b0;
            m_od    = '0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_pend  = expect_fn(in_data);
                    m_left  = NCHUNK;
                    m_phase = 1;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_od    = m_pend;
                        m_ov    = 1'b1;
                        m_phase = 2;
                    end
                end
                default: if (out_ready) begin
                    m_ov    = 1'b0;
                    m_phase = 0;
                end
            endcase
        end
    end

    logic chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_out_valid", 128'(out_valid), 128'(m_ov));
            chk("cyc_in_ready", 128'(in_ready), 128'(m_phase == 0));
            chk("cyc_busy", 128'(busy), 128'(m_phase != 0));
            chk("cyc_out_data", out_data, m_od);
        end
    end

    task automatic send(input logic [127:0] d, input int hold,
                        output logic [127:0] got, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("idle_before_send", 128'(in_ready), 128'(1'b1));
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        lat = 0;
        while (!out_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        got = out_data;
        repeat (hold) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [127:0] got;
        logic [127:0] d;
        logic [7:0]   inv;
        int           lat;

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_m[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3)
                      ^ rotl(inv, 4) ^ 8'h63;
        end
        chk("model_sbox_00", 128'(sbox_m[8'h00]), 128'(8'h63));
        chk("model_sbox_53", 128'(sbox_m[8'h53]), 128'(8'hed));
        chk("model_sbox_ff", 128'(sbox_m[8'hff]), 128'(8'h16));
        chk("model_sbox_01", 128'(sbox_m[8'h01]), 128'(8'h7c));
        chk("model_sbox_05", 128'(sbox_m[8'h05]), 128'(8'h6b));

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;
        chk("reset_out_valid", 128'(out_valid), 128'(1'b0));
        chk("reset_out_data", out_data, 128'h0);
        chk("reset_in_ready", 128'(in_ready), 128'(1'b1));
        chk("reset_busy", 128'(busy), 128'(1'b0));

        send(128'h0, 0, got, lat);
        chk("zero_latency", 128'(lat), 128'(NCHUNK));
`ifndef SUBBYTES_SHIFTROWS_EN
        chk("zero_data", got, {16{8'h63}});
        send({16{8'h53}}, 0, got, lat);
        chk("x53_data", got, {16{8'hed}});
        send({16{8'hff}}, 0, got, lat);
        chk("xff_data", got, {16{8'h16}});
        send({16{8'h01}}, 0, got, lat);
        chk("x01_data", got, {16{8'h7c}});
`else
        chk("zero_data", got, {16{8'h63}});
`endif

        send({16{8'h53}}, 10, got, lat);
        chk("hold_latency", 128'(lat), 128'(NCHUNK));

        for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'(i);
        send(d, 0, got, lat);
`ifdef SUBBYTES_SHIFTROWS_EN
        chk("inc_byte1_sr", 128'(got[15:8]), 128'(8'h6b));
`else
        chk("inc_low_word", 128'(got[31:0]), 128'(32'h7b777c63));
`endif

        in_valid = 1'b1;
        in_data  = {16{8'ha5}};
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_out_valid", 128'(out_valid), 128'(1'b0));
        chk("midrst_out_data", out_data, 128'h0);
        chk("midrst_busy", 128'(busy), 128'(1'b0));
        chk("midrst_in_ready", 128'(in_ready), 128'(1'b1));
        send(128'h0, 0, got, lat);
        chk("midrst_after", got, {16{8'h63}});

        for (int i = 0; i < 1500; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 99) == 0);
            @(posedge clk); #1;
        end
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (NCHUNK + 3) begin
            @(posedge clk); #1;
        end
        chk("drain_idle", 128'(in_ready), 128'(1'b1));

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
